// File: rtl/audio_pkg.sv
// Shared types for the audio sample path: sample width, sample type and
// the sample queue's sequencing states.
package audio_pkg;

    localparam int SMPL_W = 16;

    typedef logic signed [SMPL_W-1:0] smpl_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        SEQ
    } q_state_t;

endpackage

// File: rtl/dp_smpl_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read
// port with one clock of latency. Contents are never reset.
module dp_smpl_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/smpl_queue.sv
// Circular left/right sample queue: captures one pair per codec valid edge
// and, once WIN pairs are held, streams the WIN newest pairs oldest-first.
module smpl_queue
    import audio_pkg::*;
#(
    parameter  int DEPTH = 1024,
    parameter  int WIN   = 1021,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrt_smpl,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rht_smpl,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rht_out,
    output logic               sequencing,
    output logic               full
);

    localparam logic [PW-1:0] WIN_P  = PW'(WIN);
    localparam logic [PW-1:0] WIN_M1 = PW'(WIN - 1);
    localparam logic [PW-1:0] ONE    = PW'(1);

    q_state_t state, next_state;

    logic          wrt_smpl_ff;
    logic          wrt_edge;
    logic          trigger;
    logic          last_seq;
    logic          start_burst;
    logic          pend;
    logic [PW-1:0] new_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] fill_cnt;
    logic [PW-1:0] seq_cnt;
    logic [PW-1:0] start_ptr;
    logic [31:0]   rdata;
    smpl_t         hold_lft;
    smpl_t         hold_rht;

    assign wrt_edge    = wrt_smpl & ~wrt_smpl_ff;
    assign trigger     = wrt_edge & (fill_cnt >= WIN_M1);
    assign last_seq    = (state == SEQ) && (seq_cnt == WIN_M1);
    assign start_burst = ((state == IDLE) && trigger) || (last_seq && (pend || trigger));
    assign full        = (fill_cnt == WIN_P);

    // A capture landing on the burst-start cycle belongs to the new window,
    // so the oldest address counts it before it reaches new_ptr.
    assign start_ptr = new_ptr + {{(PW-1){1'b0}}, wrt_edge} - WIN_P;

    dp_smpl_ram #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) u_ram (
        .clk  (clk),
        .we   (wrt_edge),
        .waddr(new_ptr),
        .wdata({lft_smpl, rht_smpl}),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = ADDR;
            ADDR:    next_state = SEQ;
            SEQ:     if (last_seq) next_state = start_burst ? ADDR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sequencing = (state == SEQ);
        lft_out    = hold_lft;
        rht_out    = hold_rht;
        if (state == SEQ) begin
            lft_out = rdata[31:16];
            rht_out = rdata[15:0];
        end
    end

    // Capture pointers, fill level, pending flag and read sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrt_smpl_ff <= 1'b0;
            new_ptr     <= '0;
            fill_cnt    <= '0;
            pend        <= 1'b0;
            rd_ptr      <= '0;
            seq_cnt     <= '0;
            hold_lft    <= '0;
            hold_rht    <= '0;
        end else begin
            wrt_smpl_ff <= wrt_smpl;
            if (wrt_edge) begin
                new_ptr <= new_ptr + ONE;
                if (fill_cnt != WIN_P) begin
                    fill_cnt <= fill_cnt + ONE;
                end
            end
            if (start_burst) begin
                rd_ptr <= start_ptr;
                pend   <= 1'b0;
            end else if (wrt_edge && (state != IDLE)) begin
                pend <= 1'b1;
            end
            case (state)
                ADDR: begin
                    rd_ptr  <= rd_ptr + ONE;
                    seq_cnt <= '0;
                end
                SEQ: begin
                    hold_lft <= rdata[31:16];
                    hold_rht <= rdata[15:0];
                    if (!last_seq) begin
                        rd_ptr  <= rd_ptr + ONE;
                        seq_cnt <= seq_cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_smpl_queue.sv
// Self-checking bench for smpl_queue with DEPTH=8, WIN=5: a fill table,
// hand-built corner sequences and randomized captures against a window model.
module tb_smpl_queue;

    localparam int DEPTH = 8;
    localparam int WIN   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               wrt_smpl;
    logic signed [15:0] lft_smpl;
    logic signed [15:0] rht_smpl;
    logic signed [15:0] lft_out;
    logic signed [15:0] rht_out;
    logic               sequencing;
    logic               full;

    always #5 clk = ~clk;

    smpl_queue #(
        .DEPTH(DEPTH),
        .WIN  (WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wrt_smpl  (wrt_smpl),
        .lft_smpl  (lft_smpl),
        .rht_smpl  (rht_smpl),
        .lft_out   (lft_out),
        .rht_out   (rht_out),
        .sequencing(sequencing),
        .full      (full)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: history of captured pairs and a schedule of expected
    // window samples keyed by the cycle they must appear on.
    typedef struct {
        int          at;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] hist[$];
    int          fill;
    bit          pend;
    int          last_data;
    logic [15:0] hold_l;
    logic [15:0] hold_r;
    bit          prev_wrt;

    typedef struct {
        logic        w;
        logic [15:0] l;
        logic [15:0] r;
        logic        e_seq;
        logic [15:0] e_l;
        logic [15:0] e_r;
        logic        e_full;
    } vec_t;

    vec_t tbl[16];

    task automatic checkOutput(input string name, input logic e_seq, input logic [15:0] e_l,
                               input logic [15:0] e_r, input logic e_full);
        checks += 4;
        if (sequencing !== e_seq) begin
            failures++;
            $display("[TB] FAIL %s sequencing cyc=%0d got=%b want=%b", name, cyc, sequencing, e_seq);
        end
        if (lft_out !== e_l) begin
            failures++;
            $display("[TB] FAIL %s lft_out cyc=%0d got=%0d want=%0d", name, cyc, lft_out, $signed(e_l));
        end
        if (rht_out !== e_r) begin
            failures++;
            $display("[TB] FAIL %s rht_out cyc=%0d got=%0d want=%0d", name, cyc, rht_out, $signed(e_r));
        end
        if (full !== e_full) begin
            failures++;
            $display("[TB] FAIL %s full cyc=%0d got=%b want=%b", name, cyc, full, e_full);
        end
    endtask

    task automatic modelReset();
        expq.delete();
        hist.delete();
        fill      = 0;
        pend      = 1'b0;
        last_data = -100;
        hold_l    = '0;
        hold_r    = '0;
        prev_wrt  = 1'b0;
    endtask

    task automatic modelExpect(output logic e_seq, output logic [15:0] e_l,
                               output logic [15:0] e_r, output logic e_full);
        e_full = (fill == WIN);
        if (expq.size() > 0 && expq[0].at == cyc) begin
            e_seq  = 1'b1;
            hold_l = expq[0].l;
            hold_r = expq[0].r;
            void'(expq.pop_front());
        end else begin
            e_seq = 1'b0;
        end
        e_l = hold_l;
        e_r = hold_r;
    endtask

    // Window = the WIN newest pairs at the cycle the burst is started.
    task automatic schedule(input int c);
        exp_t e;
        for (int i = 0; i < WIN; i++) begin
            e.at = c + 2 + i;
            e.l  = hist[hist.size() - WIN + i][31:16];
            e.r  = hist[hist.size() - WIN + i][15:0];
            expq.push_back(e);
        end
        last_data = c + WIN + 1;
    endtask

    task automatic modelStep();
        bit edge_now;
        edge_now = wrt_smpl && !prev_wrt;
        prev_wrt = wrt_smpl;
        if (edge_now) begin
            hist.push_back({lft_smpl, rht_smpl});
            if (fill < WIN) fill++;
            if (fill == WIN) begin
                if (cyc > last_data) schedule(cyc);
                else pend = 1'b1;
            end
        end
        if (pend && cyc == last_data) begin
            schedule(cyc);
            pend = 1'b0;
        end
    endtask

    task automatic stepCycle();
        logic        s, f;
        logic [15:0] l, r;
        @(negedge clk);
        modelExpect(s, l, r, f);
        checkOutput("model", s, l, r, f);
        modelStep();
        cyc++;
    endtask

    task automatic applyStimulus(input logic w, input logic [15:0] l, input logic [15:0] r);
        @(posedge clk);
        #1;
        wrt_smpl = w;
        lft_smpl = l;
        rht_smpl = r;
        stepCycle();
    endtask

    task automatic capture(input int n, input int hi, input int lo);
        for (int i = 0; i < hi; i++) applyStimulus(1'b1, 16'(n), 16'(-n));
        for (int i = 0; i < lo; i++) applyStimulus(1'b0, 16'(n), 16'(-n));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, lft_smpl, rht_smpl);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        wrt_smpl = 1'b0;
        @(negedge clk);
        checkOutput("reset", 1'b0, 16'h0, 16'h0, 1'b0);
        modelReset();
        cyc++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stepCycle();
    endtask

    initial begin
        logic        s, f;
        logic [15:0] l, r;
        int          n;

        rst      = 1'b1;
        wrt_smpl = 1'b0;
        lft_smpl = '0;
        rht_smpl = '0;
        modelReset();

        // Fill table: captures 1..5 on even cycles, burst data on cycles 10..14.
        for (int c = 0; c < 16; c++) begin
            n             = (c <= 8) ? (c / 2 + 1) : 5;
            tbl[c].w      = (c % 2 == 0) && (c <= 8);
            tbl[c].l      = 16'(n);
            tbl[c].r      = 16'(-n);
            tbl[c].e_seq  = (c >= 10) && (c <= 14);
            tbl[c].e_l    = (c < 10) ? 16'(0) : ((c <= 14) ? 16'(c - 9) : 16'(5));
            tbl[c].e_r    = (c < 10) ? 16'(0) : ((c <= 14) ? 16'(9 - c) : 16'(-5));
            tbl[c].e_full = (c >= 9);
        end

        #2;
        checkOutput("reset0", 1'b0, 16'h0, 16'h0, 1'b0);
        doReset();

        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            wrt_smpl = tbl[c].w;
            lft_smpl = tbl[c].l;
            rht_smpl = tbl[c].r;
            @(negedge clk);
            modelExpect(s, l, r, f);
            checkOutput("table", tbl[c].e_seq, tbl[c].e_l, tbl[c].e_r, tbl[c].e_full);
            modelStep();
            cyc++;
        end

        $display("[TB] slide and wrap");
        for (int k = 6; k <= 10; k++) begin
            capture(k, 1, 1);
            idle(7);
        end

        $display("[TB] level hold");
        doReset();
        for (int k = 1; k <= 4; k++) capture(k, 1, 1);
        capture(5, 50, 1);
        idle(8);

        $display("[TB] pending");
        doReset();
        for (int k = 1; k <= 4; k++) capture(k, 1, 1);
        applyStimulus(1'b1, 16'(5), 16'(-5));
        idle(2);
        applyStimulus(1'b1, 16'(6), 16'(-6));
        applyStimulus(1'b0, 16'(6), 16'(-6));
        applyStimulus(1'b1, 16'(7), 16'(-7));
        idle(15);

        $display("[TB] reset mid-burst");
        doReset();
        for (int k = 1; k <= 5; k++) capture(k, 1, 1);
        idle(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid", 1'b0, 16'h0, 16'h0, 1'b0);
        modelReset();
        cyc++;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wrt_smpl = 1'b0;
        stepCycle();
        for (int k = 11; k <= 15; k++) capture(k, 1, 1);
        idle(10);

        $display("[TB] random");
        doReset();
        for (int k = 0; k < 200; k++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) applyStimulus(1'b1, l, r);
            for (int i = 0; i < int'($urandom_range(2, 5)); i++) applyStimulus(1'b0, l, r);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 8)));
        end
        idle(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
